// File: rtl/br_upd_queue_pkg.sv
// br_pkg: shared types and constants for the branch-predictor update queue.
//
// Contents:
//   pd_type_e      resolved branch kind (00 none, 01 cond, 10 call, 11 return)
//   br_upd_rec_t   one queued predictor-update record
//   BR_UPD_DEPTH   default queue depth
//   sat_inc16      16-bit saturating increment
package br_pkg;

  typedef enum logic [1:0] {
    PD_NONE = 2'b00,
    PD_COND = 2'b01,
    PD_CALL = 2'b10,
    PD_RET  = 2'b11
  } pd_type_e;

  localparam int BR_UPD_DEPTH = 4;

  typedef struct packed {
    pd_type_e    pd_type;
    logic [31:0] pc;
    logic [31:0] target;
    logic        jump;
    logic        mispred;
  } br_upd_rec_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/br_upd_queue_if.sv
// br_upd_if: bundle between the EX stage, the update queue and the predictor.
//
// Signals:
//   EX_pd_type / EX_pc_of_br / EX_br_target / EX_br_jump / EX_br
//                        resolved branch record from EX (pd_type 00 = none)
//   upd_ready            predictor accepts the head record this cycle
//   upd_valid            head record is presented
//   upd_pc / upd_target / upd_type / upd_jump / upd_mispred
//                        head record fields
//   q_count              occupancy, $clog2(DEPTH)+1 bits
//   drop_cnt             saturating count of records lost to overflow
//
// Modports:
//   slave   the queue's view
//   master  the environment's view (EX stage plus predictor)
interface br_upd_if
  import br_pkg::*;
#(
  parameter int DEPTH = BR_UPD_DEPTH
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [1:0]    EX_pd_type;
  logic [31:0]   EX_pc_of_br;
  logic [31:0]   EX_br_target;
  logic          EX_br_jump;
  logic          EX_br;
  logic          upd_ready;

  logic          upd_valid;
  logic [31:0]   upd_pc;
  logic [31:0]   upd_target;
  logic [1:0]    upd_type;
  logic          upd_jump;
  logic          upd_mispred;
  logic [CW-1:0] q_count;
  logic [15:0]   drop_cnt;

  modport slave (
    input  EX_pd_type, EX_pc_of_br, EX_br_target, EX_br_jump, EX_br, upd_ready,
    output upd_valid, upd_pc, upd_target, upd_type, upd_jump, upd_mispred,
           q_count, drop_cnt
  );

  modport master (
    output EX_pd_type, EX_pc_of_br, EX_br_target, EX_br_jump, EX_br, upd_ready,
    input  upd_valid, upd_pc, upd_target, upd_type, upd_jump, upd_mispred,
           q_count, drop_cnt
  );

endinterface

// File: rtl/br_upd_queue_fifo.sv
// br_upd_fifo: circular record store with read/write pointers and occupancy.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   i_push               append i_wdata at the tail
//   i_pop                retire the head entry
//   i_ovw                replace the youngest entry with i_wdata (no pointer move)
//   i_wdata              record to write
//   o_head               head entry (registered storage)
//   o_youngest_mispred   mispred flag of the youngest entry
//   o_count              occupancy; the only full/empty indicator
//
// The caller guarantees i_push and i_ovw are never both set, i_pop only
// when non-empty, and i_push only when not full or popping.
module br_upd_fifo
  import br_pkg::*;
#(
  parameter int DEPTH = BR_UPD_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_push,
  input  logic                   i_pop,
  input  logic                   i_ovw,
  input  br_upd_rec_t            i_wdata,
  output br_upd_rec_t            o_head,
  output logic                   o_youngest_mispred,
  output logic [$clog2(DEPTH):0] o_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  br_upd_rec_t   r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;

  logic [AW-1:0] w_yaddr;
  logic [AW-1:0] w_waddr;
  logic          w_we;

  // Pointers are exactly log2(DEPTH) wide, so wrap is free.
  assign w_yaddr = r_wptr - AW'(1);
  assign w_waddr = i_push ? r_wptr : w_yaddr;
  assign w_we    = !rst && (i_push || i_ovw);

  always_ff @(posedge clk) begin
    if (w_we) begin
      r_mem[w_waddr] <= i_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (i_push) begin
        r_wptr <= r_wptr + AW'(1);
      end
      if (i_pop) begin
        r_rptr <= r_rptr + AW'(1);
      end
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head             = r_mem[r_rptr];
  assign o_youngest_mispred = r_mem[w_yaddr].mispred;
  assign o_count            = r_count;

endmodule

// File: rtl/br_upd_queue.sv
// br_upd_queue: buffers resolved-branch records from EX and feeds them in
// order to the branch predictor's update port.
//
// Ports:
//   clk    single clock, rising edge
//   rst    synchronous active-high reset
//   bus    br_upd_if.slave: EX_* record in, upd_* head record out with
//          upd_valid/upd_ready handshake, q_count occupancy, drop_cnt
//
// Overflow policy when full and nothing leaves this cycle:
//   - ordinary record: dropped
//   - mispredict record: replaces the youngest entry unless that entry is
//     itself a mispredict, in which case the incoming one is dropped
//   drop_cnt counts every such overflow event and saturates at 16'hFFFF.
module br_upd_queue
  import br_pkg::*;
#(
  parameter int DEPTH = BR_UPD_DEPTH
) (
  input  logic    clk,
  input  logic    rst,
  br_upd_if.slave bus
);
  localparam int CW = $clog2(DEPTH) + 1;

  br_upd_rec_t   w_in_rec;
  br_upd_rec_t   w_head;
  logic [CW-1:0] w_count;
  logic          w_youngest_mispred;
  logic          w_enq_req;
  logic          w_valid;
  logic          w_full;
  logic          w_deq;
  logic          w_push;
  logic          w_ovw;
  logic          w_drop;
  logic          w_show;
  logic [15:0]   r_drop_cnt;

  assign w_in_rec = '{
    pd_type: pd_type_e'(bus.EX_pd_type),
    pc:      bus.EX_pc_of_br,
    target:  bus.EX_br_target,
    jump:    bus.EX_br_jump,
    mispred: bus.EX_br
  };

  assign w_enq_req = (pd_type_e'(bus.EX_pd_type) != PD_NONE);
  assign w_valid   = (w_count != '0);
  assign w_full    = (w_count == CW'(DEPTH));
  // upd_valid is derived from the registered count, so a record arriving
  // into an empty queue cannot be dequeued in the same cycle.
  assign w_deq     = w_valid && bus.upd_ready;
  assign w_push    = w_enq_req && (!w_full || w_deq);
  assign w_drop    = w_enq_req && w_full && !w_deq;
  assign w_ovw     = w_drop && bus.EX_br && !w_youngest_mispred;

  br_upd_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk                (clk),
    .rst                (rst),
    .i_push             (w_push),
    .i_pop              (w_deq),
    .i_ovw              (w_ovw),
    .i_wdata            (w_in_rec),
    .o_head             (w_head),
    .o_youngest_mispred (w_youngest_mispred),
    .o_count            (w_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_drop_cnt <= '0;
    end else if (w_drop) begin
      r_drop_cnt <= sat_inc16(r_drop_cnt);
    end
  end

  // Head fields read zero while reset is asserted and whenever the queue is
  // empty, so stale storage never shows on the update port.
  assign w_show          = w_valid && !rst;

  assign bus.upd_valid   = w_valid;
  assign bus.upd_pc      = w_show ? w_head.pc      : 32'h0;
  assign bus.upd_target  = w_show ? w_head.target  : 32'h0;
  assign bus.upd_type    = w_show ? 2'(w_head.pd_type) : 2'b00;
  assign bus.upd_jump    = w_show ? w_head.jump    : 1'b0;
  assign bus.upd_mispred = w_show ? w_head.mispred : 1'b0;
  assign bus.q_count     = w_count;
  assign bus.drop_cnt    = r_drop_cnt;

endmodule

// File: doc/br_upd_queue.md
BR_UPD_QUEUE -- requirements
Module: br_upd_queue

Interface
REQ-001 Parameter: DEPTH, default 4, queue entries; SHALL be a power of two, minimum 2.
REQ-002 Port: clk  in  1  single clock; all state updates on its rising edge.
REQ-003 Port: rst  in  1  reset, synchronous, active-high.
REQ-004 Port: EX_pd_type  in  2  resolved branch kind, already stall-masked; 00 = no record this cycle.
REQ-005 Port: EX_pc_of_br  in  32  PC of the resolved branch.
REQ-006 Port: EX_br_target  in  32  branch target, computed without prediction.
REQ-007 Port: EX_br_jump  in  1  branch actually taken.
REQ-008 Port: EX_br  in  1  prediction was wrong (redirect issued this cycle).
REQ-009 Port: upd_ready  in  1  predictor accepts an update this cycle.
REQ-010 Port: upd_valid  out  1  head record presented to the predictor.
REQ-011 Port: upd_pc / upd_target  out  32 each  head record PC / target.
REQ-012 Port: upd_type  out  2; upd_jump  out  1; upd_mispred  out  1  head record fields.
REQ-013 Port: q_count  out  log2(DEPTH)+1  current occupancy.
REQ-014 Port: drop_cnt  out  16  saturating count of records lost to overflow.

Function
REQ-015 Enqueue request SHALL be EX_pd_type != 00; the record is {pd_type, pc, target, jump, EX_br}.
REQ-016 Dequeue SHALL occur when upd_valid && upd_ready; upd_valid SHALL equal (q_count != 0).
REQ-017 Outputs SHALL come from registered head storage; no combinational path from EX_* to upd_*. Minimum enqueue-to-upd_valid latency is 1 cycle.
REQ-018 Records SHALL leave in arrival order; upd_* SHALL stay stable while upd_valid && !upd_ready.
REQ-019 Not full: enqueue SHALL always be accepted.
REQ-020 Full with no dequeue: a non-mispredict incoming record SHALL be dropped, and drop_cnt SHALL increment.
REQ-021 Full with no dequeue and incoming EX_br=1: the youngest stored entry SHALL be overwritten, unless that entry has mispred=1, in which case the incoming record is dropped. drop_cnt SHALL increment in both cases.
REQ-022 Full with simultaneous dequeue: the enqueue SHALL be accepted; q_count stays DEPTH; no drop.
REQ-023 Empty with simultaneous enqueue and upd_ready: the record SHALL be stored, and the dequeue SHALL NOT occur that cycle.
REQ-024 Read and write pointers SHALL wrap modulo DEPTH; q_count SHALL be the sole full/empty indicator.
REQ-025 drop_cnt SHALL saturate at 16'hFFFF.

Reset
REQ-026 rst=1 SHALL clear pointers and q_count to 0, and set upd_valid=0 and drop_cnt=0, on the next clk edge regardless of other inputs.
REQ-027 During reset, upd_pc/upd_target/upd_type/upd_jump/upd_mispred SHALL read 0.
REQ-028 Reset mid-operation SHALL discard all queued records; inputs presented in the reset cycle SHALL be ignored.

Structure
REQ-029 Shared package br_pkg SHALL hold: pd_type encoding constants (00 none, 01 cond, 10 call, 11 return), the br_upd_rec_t packed struct, and the DEPTH default.
REQ-030 Storage and pointers SHALL live in one sub-module br_upd_fifo.
REQ-031 The overflow/overwrite policy and drop_cnt SHALL live in br_upd_queue.

Verification
REQ-032 Single record:
- Stimulus: reset, enqueue {01, 0x1C000010, 0x1C000040, 1, 0}, upd_ready=1.
- Response: upd_valid=1 one cycle later with those fields; q_count returns to 0 the cycle after.
REQ-033 Backpressure:
- Stimulus: upd_ready=0; enqueue 4 records with PCs 0x100, 0x104, 0x108, 0x10C; then a 5th non-mispredict at 0x110.
- Response: q_count=4, drop_cnt=1; release upd_ready → PCs drain 0x100..0x10C in order.
REQ-034 Mispredict overwrite:
- Stimulus: queue full, all mispred=0; enqueue EX_br=1 at PC 0x200.
- Response: the 4th dequeued PC is 0x200; drop_cnt=1.
REQ-035 Full plus simultaneous dequeue:
- Stimulus: queue full, enqueue while upd_ready=1.
- Response: q_count stays 4, drop_cnt unchanged, new record dequeued last.
REQ-036 Reset mid-operation:
- Stimulus: 3 entries queued, assert rst for 1 cycle with an enqueue present.
- Response: upd_valid=0, q_count=0, drop_cnt=0 the next cycle.
REQ-037 Saturation:
- Stimulus: force 65536 overflow drops.
- Response: drop_cnt holds 16'hFFFF.
